// File: rtl/edge_detector_pkg.sv
// Shared constants and types for the edge detector block.
package edge_detector_pkg;
  localparam int MAX_SYNC_STAGES = 4;
  localparam int EDGE_CNT_W      = 8;
  typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;
endpackage

// File: rtl/edge_sync_chain.sv
// Synchronizer flop chain; on reset every stage loads the raw input so no
// stale level can masquerade as an edge after release.
module edge_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (STAGES == 0) begin : g_wire
    assign q_o = d_i;
  end else begin : g_chain
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        for (int i = 0; i < STAGES; i++) sync_q[i] <= d_i;
      end else begin
        sync_q[0] <= d_i;
        for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign q_o = sync_q[STAGES-1];
  end
endmodule

// File: rtl/edge_detector.sv
// Per-bit rising/falling edge detector with optional input synchronizer.
// EDGE_DETECTOR_COUNT_EN adds per-bit 8-bit saturating edge counters.
module edge_detector
  import edge_detector_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in,
  output logic [WIDTH-1:0]            positive_edge,
  output logic [WIDTH-1:0]            negative_edge
`ifdef EDGE_DETECTOR_COUNT_EN
  ,
  output logic [WIDTH*EDGE_CNT_W-1:0] edge_count
`endif
);
  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_cfg
    $error("edge_detector: SYNC_STAGES out of range 0..%0d", MAX_SYNC_STAGES);
  end

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cur_q, prev_q;

  edge_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (in),
    .q_o   (s)
  );

  // History loads the live input in reset so release never yields an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q  <= in;
      prev_q <= in;
    end else begin
      cur_q  <= s;
      prev_q <= cur_q;
    end
  end

  assign positive_edge = rst ? (cur_q & ~prev_q) : '0;
  assign negative_edge = rst ? (~cur_q & prev_q) : '0;

`ifdef EDGE_DETECTOR_COUNT_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    edge_cnt_t cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if ((positive_edge[i] || negative_edge[i]) && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign edge_count[i*EDGE_CNT_W +: EDGE_CNT_W] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_edge_detector.sv
// Randomized self-checking bench for edge_detector: DUT A (WIDTH=1, no sync)
// and DUT B (WIDTH=4, SYNC_STAGES=2) checked against a sample-log model.
module tb_edge_detector;
  localparam int NMAX = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_a;
  logic [3:0] in_b;
  logic       pos_a, neg_a;
  logic [3:0] pos_b, neg_b;
`ifdef EDGE_DETECTOR_COUNT_EN
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  edge_detector #(.WIDTH(1), .SYNC_STAGES(0)) dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .positive_edge(pos_a), .negative_edge(neg_a)
`ifdef EDGE_DETECTOR_COUNT_EN
    , .edge_count(cnt_a)
`endif
  );

  edge_detector #(.WIDTH(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_b),
    .positive_edge(pos_b), .negative_edge(neg_b)
`ifdef EDGE_DETECTOR_COUNT_EN
    , .edge_count(cnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: log of inputs and reset seen at each posedge. After posedge n,
  // cur is the input sampled L posedges earlier, clamped to the last reset
  // posedge (where every flop took the live input); prev is one sample older.
  logic [3:0] la [NMAX];
  logic [3:0] lb [NMAX];
  logic       rl [NMAX];
  int         lr [NMAX];
  int         cyc = -1;
  int         ecnt_a;
  int         ecnt_b [4];

  function automatic logic [3:0] hist(input bit b, input int n, input int lag);
    int k;
    k = n - lag;
    if (k < lr[n]) k = lr[n];
    return b ? lb[k] : la[k];
  endfunction

  function automatic logic [3:0] exp_pos(input bit b, input int n, input int L);
    if (!rl[n]) return 4'h0;
    return hist(b, n, L) & ~hist(b, n, L + 1);
  endfunction

  function automatic logic [3:0] exp_neg(input bit b, input int n, input int L);
    if (!rl[n]) return 4'h0;
    return ~hist(b, n, L) & hist(b, n, L + 1);
  endfunction

  always @(posedge clk) begin
    logic [3:0] ev;
    if (cyc < NMAX - 1) begin
      cyc++;
      la[cyc] = {3'b000, in_a};
      lb[cyc] = in_b;
      rl[cyc] = rst;
      lr[cyc] = (!rst || cyc == 0) ? cyc : lr[cyc-1];
      if (!rst) begin
        ecnt_a = 0;
        for (int i = 0; i < 4; i++) ecnt_b[i] = 0;
      end else begin
        ev = exp_pos(1'b0, cyc - 1, 0) | exp_neg(1'b0, cyc - 1, 0);
        if (ev[0] && ecnt_a < 255) ecnt_a++;
        ev = exp_pos(1'b1, cyc - 1, 2) | exp_neg(1'b1, cyc - 1, 2);
        for (int i = 0; i < 4; i++) if (ev[i] && ecnt_b[i] < 255) ecnt_b[i]++;
      end
      #1;
      chk("pos_a", {31'd0, pos_a}, {28'd0, exp_pos(1'b0, cyc, 0)});
      chk("neg_a", {31'd0, neg_a}, {28'd0, exp_neg(1'b0, cyc, 0)});
      chk("pos_b", {28'd0, pos_b}, {28'd0, exp_pos(1'b1, cyc, 2)});
      chk("neg_b", {28'd0, neg_b}, {28'd0, exp_neg(1'b1, cyc, 2)});
      chk("overlap_b", {28'd0, pos_b & neg_b}, 32'd0);
`ifdef EDGE_DETECTOR_COUNT_EN
      chk("cnt_a", {24'd0, cnt_a}, ecnt_a);
      for (int i = 0; i < 4; i++) chk("cnt_b", {24'd0, cnt_b[i*8 +: 8]}, ecnt_b[i]);
`endif
    end
  end

  // Stimulus-side pulse tallies, sampled at negedge before any input change.
  int sp_a, sn_a, sp_b;

  task automatic step();
    @(negedge clk);
    sp_a += int'(pos_a);
    sn_a += int'(neg_a);
    sp_b += $countones(pos_b);
  endtask

  task automatic clr();
    sp_a = 0; sn_a = 0; sp_b = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    rst = 1'b0; in_a = 1'b0; in_b = 4'h0;
    clr();
    repeat (2) step();
    chk("reset_pos_a", {31'd0, pos_a}, 32'd0);
    rst = 1'b1;
    clr();
    repeat (10) step();
    chk("idle_no_pulse", sp_a + sn_a + sp_b, 32'd0);

    // Reset with the input already high must not produce a rise.
    rst = 1'b0; in_a = 1'b1; in_b = 4'hF;
    repeat (2) step();
    rst = 1'b1;
    clr();
    repeat (10) step();
    chk("rst_in1_no_rise", sp_a + sp_b, 32'd0);

    in_a = 1'b0;
    repeat (3) step();
    in_a = 1'b1;
    step();
    chk("rise_pos", {31'd0, pos_a}, 32'd1);
    chk("rise_neg", {31'd0, neg_a}, 32'd0);
    step();
    chk("rise_width", {31'd0, pos_a}, 32'd0);
    repeat (3) step();
    in_a = 1'b0;
    step();
    chk("fall_neg", {31'd0, neg_a}, 32'd1);
    step();
    chk("fall_width", {31'd0, neg_a}, 32'd0);

    clr();
    for (int t = 0; t < 10; t++) begin
      repeat ($urandom_range(1, 128)) step();
      in_a = ~in_a;
    end
    repeat (3) step();
    chk("rand_pos_cnt", sp_a, 5);
    chk("rand_neg_cnt", sn_a, 5);

    clr();
    for (int t = 0; t < 20; t++) begin
      in_a = ~in_a;
      step();
    end
    repeat (2) step();
    chk("toggle_pos_cnt", sp_a, 10);
    chk("toggle_neg_cnt", sn_a, 10);

    in_b = 4'h0;
    repeat (5) step();
    in_b = 4'b1010;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (pos_b != 4'h0) begin
        lat = i;
        break;
      end
    end
    chk("b_latency", lat, 3);
    chk("b_pos", {28'd0, pos_b}, 32'hA);
    chk("b_neg", {28'd0, neg_b}, 32'h0);
    step();
    chk("b_width", {28'd0, pos_b}, 32'h0);

    for (int t = 0; t < 200; t++) begin
      in_a = 1'($urandom_range(0, 1));
      in_b = 4'($urandom_range(0, 15));
      step();
    end

    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    clr();
    for (int t = 0; t < 300; t++) begin
      in_a = ~in_a;
      step();
    end
    repeat (4) step();
    chk("sat_pulses", sp_a + sn_a, 300);
`ifdef EDGE_DETECTOR_COUNT_EN
    chk("cnt_saturate", {24'd0, cnt_a}, 32'd255);
`endif

    in_a = ~in_a;
    rst = 1'b0;
    step();
    chk("mid_rst_quiet", {31'd0, pos_a | neg_a}, 32'd0);
`ifdef EDGE_DETECTOR_COUNT_EN
    chk("mid_rst_cnt", {24'd0, cnt_a}, 32'd0);
`endif
    rst = 1'b1;
    clr();
    repeat (5) step();
    chk("mid_rst_release", sp_a + sn_a, 32'd0);

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
